// File: rtl/harmonic_sequencer.sv
// Per-sample sweep controller for the harmonic amplitude scaler: restarts Scale_Mult,
// then steps it once per clock while emitting index, phase increment and level per harmonic.
module harmonic_sequencer #(
  parameter int          DIV_BIT  = 8,
  parameter int          HARM_BIT = 7,
  parameter int          INC_BIT  = 16,
  parameter int unsigned NYQ_INC  = 2**(INC_BIT-1)
) (
  input  logic                i_Clock,
  input  logic                i_Reset_N,
  input  logic                i_Sample_Strobe,
  input  logic [HARM_BIT-1:0] i_Harm_Count,
  input  logic [INC_BIT-1:0]  i_Base_Inc,
  input  logic [DIV_BIT-1:0]  i_Mult,
  output logic                o_Mult_Restart,
  output logic                o_Mult_Start,
  output logic                o_Harm_Valid,
  output logic [HARM_BIT-1:0] o_Harm_Index,
  output logic [INC_BIT-1:0]  o_Harm_Inc,
  output logic [DIV_BIT-1:0]  o_Harm_Level,
  output logic                o_Busy,
  output logic                o_Done,
  output logic                o_Overrun
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RESTART = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [INC_BIT:0] NYQ_LIM = NYQ_INC[INC_BIT:0];

  logic [1:0]          state_q, state_d;
  logic [HARM_BIT-1:0] count_q, count_d;
  logic [INC_BIT-1:0]  base_q, base_d;
  logic [HARM_BIT-1:0] index_q, index_d;
  // One bit wider than the increment so the Nyquist test is made before any wrap.
  logic [INC_BIT:0]    acc_q, acc_d;
  logic                valid_q, valid_d;
  logic [HARM_BIT-1:0] hidx_q, hidx_d;
  logic [INC_BIT-1:0]  hinc_q, hinc_d;
  logic [DIV_BIT-1:0]  hlvl_q, hlvl_d;
  logic                overrun_q, overrun_d;
  logic                term;

  assign term = (index_q == count_q) || (i_Mult == '0) || (acc_q >= NYQ_LIM);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    base_d    = base_q;
    index_d   = index_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    hidx_d    = hidx_q;
    hinc_d    = hinc_q;
    hlvl_d    = hlvl_q;
    overrun_d = i_Sample_Strobe && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (i_Sample_Strobe) begin
          count_d = i_Harm_Count;
          base_d  = i_Base_Inc;
          index_d = '0;
          acc_d   = {1'b0, i_Base_Inc};
          state_d = S_RESTART;
        end
      end
      S_RESTART: state_d = S_EMIT;
      S_EMIT: begin
        if (term) begin
          state_d = S_DONE;
        end else begin
          valid_d = 1'b1;
          hidx_d  = index_q;
          hinc_d  = acc_q[INC_BIT-1:0];
          hlvl_d  = i_Mult;
          index_d = index_q + 1'b1;
          acc_d   = acc_q + {1'b0, base_q};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      base_q    <= '0;
      index_q   <= '0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      hidx_q    <= '0;
      hinc_q    <= '0;
      hlvl_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      base_q    <= base_d;
      index_q   <= index_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      hidx_q    <= hidx_d;
      hinc_q    <= hinc_d;
      hlvl_q    <= hlvl_d;
      overrun_q <= overrun_d;
    end
  end

  // Scale_Mult controls are decoded straight from state so they can never overlap.
  assign o_Mult_Restart = (state_q == S_RESTART);
  assign o_Mult_Start   = (state_q == S_EMIT) && !term;
  assign o_Harm_Valid   = valid_q;
  assign o_Harm_Index   = hidx_q;
  assign o_Harm_Inc     = hinc_q;
  assign o_Harm_Level   = hlvl_q;
  assign o_Busy         = (state_q != S_IDLE);
  assign o_Done         = (state_q == S_DONE);
  assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Scoreboard bench for harmonic_sequencer with a behavioural Scale_Mult model on i_Mult.
module tb_harmonic_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe;
  logic [6:0] harm_count;
  logic [15:0] base_inc;
  logic [7:0] mult = 8'd0;
  logic       o_Mult_Restart, o_Mult_Start, o_Harm_Valid, o_Busy, o_Done, o_Overrun;
  logic [6:0] o_Harm_Index;
  logic [15:0] o_Harm_Inc;
  logic [7:0] o_Harm_Level;

  logic [7:0] init_val = 8'd0;
  logic [7:0] scale_val = 8'd0;

  typedef struct {
    int idx;
    int inc;
    int lvl;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int restart_cnt = 0, start_cnt = 0, done_cnt = 0, overrun_cnt = 0, valid_cnt = 0;
  int done_cyc = 0, overrun_cyc = 0, last_valid_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scale_Mult stand-in: load on restart, subtract scale (floored at 0) on start.
  always @(posedge clk) begin
    if (o_Mult_Restart) mult <= init_val;
    else if (o_Mult_Start) mult <= (mult > scale_val) ? mult - scale_val : 8'd0;
  end

  harmonic_sequencer dut (
    .i_Clock        (clk),
    .i_Reset_N      (rst_n),
    .i_Sample_Strobe(strobe),
    .i_Harm_Count   (harm_count),
    .i_Base_Inc     (base_inc),
    .i_Mult         (mult),
    .o_Mult_Restart (o_Mult_Restart),
    .o_Mult_Start   (o_Mult_Start),
    .o_Harm_Valid   (o_Harm_Valid),
    .o_Harm_Index   (o_Harm_Index),
    .o_Harm_Inc     (o_Harm_Inc),
    .o_Harm_Level   (o_Harm_Level),
    .o_Busy         (o_Busy),
    .o_Done         (o_Done),
    .o_Overrun      (o_Overrun)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic push_exp(input int idx, input int inc, input int lvl);
    exp_t e;
    e.idx = idx; e.inc = inc; e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_Mult_Restart) restart_cnt++;
      if (o_Mult_Start) start_cnt++;
      if (o_Mult_Restart || o_Mult_Start)
        chk("restart_start_exclusive", int'(o_Mult_Restart & o_Mult_Start), 0);
      if (o_Done) begin done_cnt++; done_cyc = cyc; end
      if (o_Overrun) begin overrun_cnt++; overrun_cyc = cyc; end
      if (o_Harm_Valid) begin
        valid_cnt++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("valid_with_no_expectation", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          $display("harmonic: idx=%0d inc=0x%04h level=%0d (exp idx=%0d inc=0x%04h level=%0d)",
                   o_Harm_Index, o_Harm_Inc, o_Harm_Level, e.idx, e.inc, e.lvl);
          chk("harm_index", int'(o_Harm_Index), e.idx);
          chk("harm_inc", int'(o_Harm_Inc), e.inc);
          chk("harm_level", int'(o_Harm_Level), e.lvl);
        end
      end
    end
  endtask

  // Drives a one-cycle strobe; c1 is the cycle number of the cycle after the sampling edge.
  task automatic pulse_strobe(input int cnt, input int base, output int c1);
    @(posedge clk);
    #1;
    strobe = 1'b1;
    harm_count = cnt[6:0];
    base_inc = base[15:0];
    @(posedge clk);
    #1;
    strobe = 1'b0;
    c1 = cyc;
    chk("busy_after_strobe", int'(o_Busy), 1);
    chk("restart_after_strobe", int'(o_Mult_Restart), 1);
  endtask

  task automatic wait_done(input int d0);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    chk("done_seen_before_timeout", int'(done_cnt != d0), 1);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("idle_after_done", int'(o_Busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, int'({o_Mult_Restart, o_Mult_Start, o_Harm_Valid, o_Busy, o_Done, o_Overrun}), 0);
    chk({tag, "_index"}, int'(o_Harm_Index), 0);
    chk({tag, "_inc"}, int'(o_Harm_Inc), 0);
    chk({tag, "_level"}, int'(o_Harm_Level), 0);
  endtask

  initial begin
    int c1, r0, s0, d0, v0, o0;
    rst_n = 1'b0;
    strobe = 1'b0;
    harm_count = '0;
    base_inc = '0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full sweep
    init_val = 8'd200; scale_val = 8'd30;
    push_exp(0, 16'h0100, 200); push_exp(1, 16'h0200, 170); push_exp(2, 16'h0300, 140);
    push_exp(3, 16'h0400, 110); push_exp(4, 16'h0500, 80);
    r0 = restart_cnt; s0 = start_cnt; d0 = done_cnt; v0 = valid_cnt;
    pulse_strobe(5, 16'h0100, c1);
    wait_done(d0);
    chk("full_done_cycle", done_cyc, c1 + 7);
    chk("full_last_valid_cycle", last_valid_cyc, c1 + 6);
    chk("full_valid_count", valid_cnt - v0, 5);
    chk("full_restart_count", restart_cnt - r0, 1);
    chk("full_start_count", start_cnt - s0, 5);

    // Amplitude cut-off
    init_val = 8'd100; scale_val = 8'd40;
    push_exp(0, 16'h0100, 100); push_exp(1, 16'h0200, 60); push_exp(2, 16'h0300, 20);
    s0 = start_cnt; d0 = done_cnt; v0 = valid_cnt;
    pulse_strobe(20, 16'h0100, c1);
    wait_done(d0);
    chk("amp_valid_count", valid_cnt - v0, 3);
    chk("amp_start_count", start_cnt - s0, 3);
    chk("amp_done_cycle", done_cyc, c1 + 5);

    // Nyquist cut-off
    init_val = 8'd250; scale_val = 8'd10;
    push_exp(0, 16'h3000, 250); push_exp(1, 16'h6000, 240);
    d0 = done_cnt; v0 = valid_cnt;
    pulse_strobe(127, 16'h3000, c1);
    wait_done(d0);
    chk("nyq_valid_count", valid_cnt - v0, 2);
    chk("nyq_done_cycle", done_cyc, c1 + 4);

    // Zero count
    init_val = 8'd200; scale_val = 8'd30;
    r0 = restart_cnt; s0 = start_cnt; d0 = done_cnt; v0 = valid_cnt;
    pulse_strobe(0, 16'h0100, c1);
    wait_done(d0);
    chk("zero_done_cycle", done_cyc, c1 + 2);
    chk("zero_restart_count", restart_cnt - r0, 1);
    chk("zero_start_count", start_cnt - s0, 0);
    chk("zero_valid_count", valid_cnt - v0, 0);

    // Overrun: second strobe sampled during an EMIT cycle with different inputs
    push_exp(0, 16'h0100, 200); push_exp(1, 16'h0200, 170); push_exp(2, 16'h0300, 140);
    push_exp(3, 16'h0400, 110); push_exp(4, 16'h0500, 80);
    r0 = restart_cnt; d0 = done_cnt; v0 = valid_cnt; o0 = overrun_cnt;
    pulse_strobe(5, 16'h0100, c1);
    @(posedge clk);
    @(posedge clk);
    #1;
    strobe = 1'b1; harm_count = 7'd1; base_inc = 16'h7000;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    wait_done(d0);
    repeat (3) @(posedge clk);
    chk("ovr_pulse_count", overrun_cnt - o0, 1);
    chk("ovr_pulse_cycle", overrun_cyc, c1 + 3);
    chk("ovr_done_count", done_cnt - d0, 1);
    chk("ovr_done_cycle", done_cyc, c1 + 7);
    chk("ovr_valid_count", valid_cnt - v0, 5);
    chk("ovr_restart_count", restart_cnt - r0, 1);

    // Reset during the third EMIT cycle
    push_exp(0, 16'h0100, 200);
    d0 = done_cnt;
    pulse_strobe(5, 16'h0100, c1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_queue_empty", exp_q.size(), 0);

    init_val = 8'd50; scale_val = 8'd10;
    push_exp(0, 16'h0100, 50); push_exp(1, 16'h0200, 40);
    r0 = restart_cnt; d0 = done_cnt; v0 = valid_cnt;
    pulse_strobe(2, 16'h0100, c1);
    wait_done(d0);
    chk("post_reset_restart_count", restart_cnt - r0, 1);
    chk("post_reset_valid_count", valid_cnt - v0, 2);
    chk("post_reset_done_cycle", done_cyc, c1 + 4);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/harmonic_sequencer.md
# harmonic_sequencer

Per-sample controller for the harmonic amplitude scaler. On every sample-rate strobe it restarts the scaler, then steps it once per clock. For each harmonic it emits the harmonic index, its phase increment and its amplitude. The sweep stops at the requested harmonic count, when the amplitude reaches zero, or when the harmonic frequency reaches Nyquist. It sits between the sample-rate timer and the Scale_Mult instance, and drives the Scale_Mult i_Restart and i_Start inputs.

## Interface
- DIV_BIT, 8: width of the scaler multiple (matches Scale_Mult DIV_BIT).
- HARM_BIT, 7: width of the harmonic count and index.
- INC_BIT, 16: width of the phase increments.
- NYQ_INC, 2**(INC_BIT-1): the sweep terminates once the harmonic increment is ≥ this value.
- i_Clock  in  1  system clock; all logic on the rising edge.
- i_Reset_N  in  1  asynchronous, active-low reset.
- i_Sample_Strobe  in  1  one-cycle pulse that starts a sweep.
- i_Harm_Count  in  HARM_BIT  maximum number of harmonics to emit; latched on an accepted strobe.
- i_Base_Inc  in  INC_BIT  fundamental phase increment; latched on an accepted strobe.
- i_Mult  in  DIV_BIT  current multiple, from Scale_Mult o_Mult.
- o_Mult_Restart  out  1  to Scale_Mult i_Restart.
- o_Mult_Start  out  1  to Scale_Mult i_Start.
- o_Harm_Valid  out  1  one-cycle qualifier for the three harmonic outputs below.
- o_Harm_Index  out  HARM_BIT  harmonic number, 0 = fundamental.
- o_Harm_Inc  out  INC_BIT  phase increment for this harmonic, (index+1)*base.
- o_Harm_Level  out  DIV_BIT  amplitude multiple for this harmonic.
- o_Busy  out  1  high while a sweep is in progress.
- o_Done  out  1  one-cycle pulse at the end of each sweep.
- o_Overrun  out  1  one-cycle pulse when a strobe is dropped.

## Operation
- **States:** IDLE, RESTART, EMIT, DONE.
- **Reset:** state goes to IDLE. All outputs, the index counter and the accumulator clear to 0.
- **IDLE:**
  - Strobe high: latch count and base; set index to 0 and acc to base; go to RESTART.
- **RESTART (1 cycle):**
  - o_Mult_Restart = 1, decoded from the state register.
  - Scale_Mult loads its initial value at the closing edge of this cycle.
  - Next state: EMIT.
- **EMIT:** term = (index == count) | (i_Mult == 0) | (acc ≥ NYQ_INC).
  - If term: go to DONE. Nothing is emitted and o_Mult_Start stays 0.
  - Otherwise, o_Mult_Start = 1 combinationally (state==EMIT & !term).
  - At the same edge, register o_Harm_Valid=1, o_Harm_Index=index, o_Harm_Inc=acc[INC_BIT-1:0] and o_Harm_Level=i_Mult.
  - Then increment index and set acc += base.
- **DONE (1 cycle):** o_Done = 1; next state IDLE.
- **o_Busy:** 1 in RESTART, EMIT and DONE.
- **Accumulator width:** acc is INC_BIT+1 bits wide. It is checked before each add, so it never exceeds NYQ_INC + base and never wraps.
- **Dropped strobe:** a strobe outside IDLE is ignored and o_Overrun pulses for 1 cycle. Latched values and the running sweep are unaffected.
- **Zero-length sweep:** i_Harm_Count = 0 emits no harmonics. RESTART and DONE still occur.
- **Zero base:** i_Base_Inc = 0 never terminates on Nyquist. The sweep ends on count or zero amplitude.
- **Simultaneous terminations:** any term condition ends the sweep identically; there is no priority difference between them.
- **Reset mid-sweep:** the sweep aborts immediately and outputs go to 0. No o_Done is issued. Scale_Mult is not reset by this block; the next RESTART reloads it.

## Timing
- Strobe sampled at edge E0 → RESTART during cycle 1 → first EMIT in cycle 2.
- First o_Harm_Valid is high in cycle 3.
- Harmonics then follow at one per clock with no gaps.
- Each o_Harm_Valid is high in the cycle after its EMIT cycle. The last valid coincides with the terminating EMIT cycle.
- o_Harm_Valid is low during DONE.
- For N emitted harmonics, the sweep spans N+3 cycles after E0 (RESTART + N EMIT + terminating EMIT + DONE).
- The sample period must be at least N+4 cycles, otherwise strobes are dropped.
- o_Mult_Start and o_Mult_Restart are each one cycle wide and are never high together.
- Earliest re-acceptance: a strobe sampled high while in IDLE, i.e. the cycle after DONE.
- o_Overrun rises 1 cycle after the offending strobe.

## Test plan
- **Full sweep:** count=5, base=0x0100, Scale_Mult initial=200, scale=30 → valid on 5 consecutive cycles.
  - Index 0–4, inc 0x0100/0x0200/0x0300/0x0400/0x0500, level 200/170/140/110/80.
  - o_Done 8 cycles after the strobe edge.
- **Amplitude cut-off:** count=20, initial=100, scale=40 → levels 100, 60, 20; mult reaches 0 and the sweep ends after 3 harmonics.
- **Nyquist cut-off:** count=127, base=0x3000, INC_BIT=16 → harmonics with inc 0x3000 and 0x6000 only; 0x9000 ≥ 0x8000 terminates.
- **Zero count:** count=0 → one restart pulse, no start pulses, no valid; o_Done 3 cycles after the strobe edge.
- **Overrun:** a second strobe during EMIT → o_Overrun pulse 1 cycle later; the first sweep's outputs are unchanged; exactly one o_Done.
- **Reset mid-sweep:** assert i_Reset_N low during the 3rd EMIT cycle → all outputs 0 immediately; after release, a new strobe restarts from index 0 with a fresh restart pulse.
